vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 65 ++++++
 tb/tb_vga_timing.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running pixel/line counters with
// combinational sync, data-enable and line/frame strobe decode.
module vga_timing #(
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       line,
    output logic       frame
);
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_RES);
    localparam logic [9:0] V_ACT    = 10'(V_RES);
    localparam logic [9:0] HS_START = 10'(H_RES + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_RES + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_RES + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_RES + V_FP + V_SYNC);

    logic [9:0] sx_q, sx_d;
    logic [9:0] sy_q, sy_d;

    // sy only advances on the edge where sx wraps back to 0.
    always_comb begin
        sx_d = sx_q + 10'd1;
        sy_d = sy_q;
        if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? 10'd0 : sy_q + 10'd1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx_q <= '0;
            sy_q <= '0;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    assign sx    = sx_q;
    assign sy    = sy_q;
    assign hsync = ~((sx_q >= HS_START) && (sx_q < HS_END));
    assign vsync = ~((sy_q >= VS_START) && (sy_q < VS_END));
    assign de    = (sx_q < H_ACT) && (sy_q < V_ACT);
    assign line  = (sx_q == 10'd0);
    assign frame = (sx_q == 10'd0) && (sy_q == V_ACT);
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default-size instance for line-level timing and a
// shrunken instance so whole frames fit in a short run.
module tb_vga_timing;
    typedef struct packed {
        logic [9:0] sx;
        logic [9:0] sy;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ln;
        logic       fr;
    } obs_t;

    typedef struct {
        string name;
        logic  rst;
        int    n;
        obs_t  exp;
    } vec_t;

    // Small geometry: 32 x 21 total, 16 x 12 active, 672 cycles per frame.
    localparam int S_HR = 16, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VR = 12, S_VF = 3, S_VS = 2, S_VB = 4;
    localparam int S_HT = S_HR + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VR + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    logic [9:0] d_sx, d_sy, s_sx, s_sy;
    logic d_hs, d_vs, d_de, d_ln, d_fr;
    logic s_hs, s_vs, s_de, s_ln, s_fr;

    int checks = 0;
    int errors = 0;
    int td = 0;
    int ts = 0;
    obs_t qd[$];
    obs_t qs[$];
    vec_t vecs[14];

    always #5 clk_pix = ~clk_pix;

    vga_timing dut_d (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(d_sx), .sy(d_sy),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .line(d_ln), .frame(d_fr)
    );

    vga_timing #(
        .H_RES(S_HR), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_RES(S_VR), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_s (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(s_sx), .sy(s_sy),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .line(s_ln), .frame(s_fr)
    );

    function automatic obs_t model(input int t, input int hr, input int hf, input int hs,
                                   input int hb, input int vr, input int vf, input int vs);
        obs_t o;
        int ht, x, y;
        ht = hr + hf + hs + hb;
        x = t % ht;
        y = t / ht;
        o.sx = 10'(x);
        o.sy = 10'(y);
        o.hs = !(x >= hr + hf && x < hr + hf + hs);
        o.vs = !(y >= vr + vf && y < vr + vf + vs);
        o.de = (x < hr) && (y < vr);
        o.ln = (x == 0);
        o.fr = (x == 0) && (y == vr);
        return o;
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input int n, input int x,
                                input int y, input logic hs, input logic vs, input logic de,
                                input logic ln, input logic fr);
        vec_t v;
        v.name = nm;
        v.rst = r;
        v.n = n;
        v.exp = '{sx: 10'(x), sy: 10'(y), hs: hs, vs: vs, de: de, ln: ln, fr: fr};
        return v;
    endfunction

    function automatic obs_t obs_d();
        return '{sx: d_sx, sy: d_sy, hs: d_hs, vs: d_vs, de: d_de, ln: d_ln, fr: d_fr};
    endfunction

    function automatic obs_t obs_s();
        return '{sx: s_sx, sy: s_sy, hs: s_hs, vs: s_vs, de: s_de, ln: s_ln, fr: s_fr};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive reset, push model predictions, compare after the edge.
    task automatic step(input logic r);
        obs_t e;
        @(negedge clk_pix);
        rst_pix = r;
        td = r ? 0 : (td + 1) % (800 * 525);
        ts = r ? 0 : (ts + 1) % S_FRAME;
        qd.push_back(model(td, 640, 16, 96, 48, 480, 10, 2));
        qs.push_back(model(ts, S_HR, S_HF, S_HS, S_HB, S_VR, S_VF, S_VS));
        @(posedge clk_pix);
        #1;
        e = qd.pop_front();
        check("sb_default", 64'(obs_d()), 64'(e));
        e = qs.pop_front();
        check("sb_small", 64'(obs_s()), 64'(e));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int frames, first_fr, second_fr, de_cnt, vs_low, hs_low, budget;
        obs_t o;

        //              name         rst n    sx   sy  hs vs de ln fr
        vecs[0]  = mk("rst_hold",   1, 2,   0,   0, 1, 1, 1, 1, 0);
        vecs[1]  = mk("release",    0, 1,   1,   0, 1, 1, 1, 0, 0);
        vecs[2]  = mk("count2",     0, 1,   2,   0, 1, 1, 1, 0, 0);
        vecs[3]  = mk("de_last",    0, 637, 639, 0, 1, 1, 1, 0, 0);
        vecs[4]  = mk("de_off",     0, 1,   640, 0, 1, 1, 0, 0, 0);
        vecs[5]  = mk("hs_pre",     0, 15,  655, 0, 1, 1, 0, 0, 0);
        vecs[6]  = mk("hs_start",   0, 1,   656, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk("hs_last",    0, 95,  751, 0, 0, 1, 0, 0, 0);
        vecs[8]  = mk("hs_end",     0, 1,   752, 0, 1, 1, 0, 0, 0);
        vecs[9]  = mk("line_end",   0, 47,  799, 0, 1, 1, 0, 0, 0);
        vecs[10] = mk("line_wrap",  0, 1,   0,   1, 1, 1, 1, 1, 0);
        vecs[11] = mk("line1",      0, 1,   1,   1, 1, 1, 1, 0, 0);
        vecs[12] = mk("midline_rst",1, 1,   0,   0, 1, 1, 1, 1, 0);
        vecs[13] = mk("resume",     0, 1,   1,   0, 1, 1, 1, 0, 0);

        for (int i = 0; i < 14; i++) begin
            repeat (vecs[i].n) step(vecs[i].rst);
            check(vecs[i].name, 64'(obs_d()), 64'(vecs[i].exp));
        end

        // Two full small frames from reset: strobe spacing and per-frame counts.
        step(1'b1);
        frames = 0; first_fr = -1; second_fr = -1;
        de_cnt = 0; vs_low = 0; hs_low = 0;
        for (int i = 0; i < 2 * S_FRAME; i++) begin
            o = obs_s();
            if (o.fr) begin
                frames++;
                if (first_fr < 0) begin
                    first_fr = i;
                    check("frame_pos", 64'({o.sx, o.sy}), 64'({10'd0, 10'(S_VR)}));
                end else if (second_fr < 0) begin
                    second_fr = i;
                end
            end
            if (i < S_FRAME) begin
                de_cnt += int'(o.de);
                vs_low += int'(!o.vs);
                hs_low += int'(!o.hs);
            end
            step(1'b0);
        end
        check("frame_count", 64'(frames), 64'd2);
        check("frame_first", 64'(first_fr), 64'(S_VR * S_HT));
        check("frame_period", 64'(second_fr - first_fr), 64'(S_FRAME));
        check("de_per_frame", 64'(de_cnt), 64'(S_HR * S_VR));
        check("vs_low_cycles", 64'(vs_low), 64'(S_VS * S_HT));
        check("hs_low_cycles", 64'(hs_low), 64'(S_HS * S_VT));

        // Frame wrap at the last pixel of the last line.
        budget = 0;
        while (!(s_sx == 10'(S_HT - 1) && s_sy == 10'(S_VT - 1)) && budget < 2 * S_FRAME) begin
            step(1'b0);
            budget++;
        end
        check("reach_last", 64'({s_sx, s_sy}), 64'({10'(S_HT - 1), 10'(S_VT - 1)}));
        step(1'b0);
        check("frame_wrap", 64'({s_sx, s_sy, s_ln}), 64'({10'd0, 10'd0, 1'b1}));

        // Mid-frame reset restarts immediately, then resumes at (1,0).
        budget = 0;
        while (!(s_sx == 10'd10 && s_sy == 10'd7) && budget < 2 * S_FRAME) begin
            step(1'b0);
            budget++;
        end
        check("reach_10_7", 64'({s_sx, s_sy}), 64'({10'd10, 10'd7}));
        step(1'b1);
        check("midframe_rst", 64'({s_sx, s_sy, s_de, s_ln, s_fr}), 64'({10'd0, 10'd0, 3'b110}));
        step(1'b0);
        check("midframe_resume", 64'({s_sx, s_sy}), 64'({10'd1, 10'd0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
